dac_waveform_player: RTL
========================

# dac_waveform_player

Waveform sample source sitting directly upstream of `dac_write`. Holds a software-loaded table of DAC codes in block RAM and, on a start pulse, streams addresses 0..`in_last_addr` to `dac_write` as a valid/ready sample stream. It repeats the table a programmable number of times, or forever. Samples are raw codes in the input encoding that `dac_write` is configured for; this block does no encoding conversion.

## Interface
- `INT_DAC_DATA_WIDTH`, 10, sample width in bits.
- `INT_MEM_DEPTH`, 1024, table depth in samples; must be a power of two.
- `INT_ADDR_WIDTH`, `$clog2(INT_MEM_DEPTH)`, address width; derived, not overridden.

Ports:
- `in_clk` in 1: single clock. Whole block is synchronous to it.
- `in_rst` in 1: synchronous, active-high reset.
- `in_wr_en` in 1: table write strobe.
- `in_wr_addr` in `INT_ADDR_WIDTH`: table write address.
- `in_wr_data` in `INT_DAC_DATA_WIDTH`: table write data.
- `in_last_addr` in `INT_ADDR_WIDTH`: last table address played. Sampled on accepted start.
- `in_loops` in 16: number of table passes. 0 means infinite. Sampled on accepted start.
- `in_start` in 1: start pulse.
- `in_stop` in 1: abort pulse.
- `in_dac_ready` in 1: downstream `dac_write` can accept a sample.
- `out_valid` in→out 1: output; `out_data` is a valid sample.
- `out_data` out `INT_DAC_DATA_WIDTH`: sample to `dac_write` `in_data`.
- `out_busy` out 1: state is not IDLE.
- `out_done` out 1: one-cycle pulse after the final sample of the final pass transfers.

## Operation
- **Transfer rule:** a sample transfers on a cycle where `out_valid && in_dac_ready`.
- **States:**
  - IDLE: waiting for start.
  - PLAY: reads still to be issued.
  - DRAIN: last read has been issued; waiting for its transfer.
- **IDLE → PLAY:** on `in_start` while `in_stop` is low.
  - Latch `in_last_addr` and `in_loops`.
  - Clear the address counter and the pass counter.
- **Read enable:** `rd_en = (state==PLAY) && (!out_valid || in_dac_ready)`.
  - The RAM output register only loads on `rd_en`.
  - So `out_data` holds while the sample is stalled.
- **Address advance** on `rd_en`:
  - If addr == last_addr: wrap to 0 and increment the pass counter.
  - Otherwise: addr+1.
- **Final read:** the read of last_addr when pass == loops−1 (and loops ≠ 0) moves PLAY → DRAIN.
  - With loops = 0 the block never enters DRAIN.
- **`out_valid`:**
  - Set by `rd_en`.
  - Cleared when a transfer occurs and there is no `rd_en` in the same cycle.
- **DRAIN → IDLE:** on the transfer of the final sample. `out_done` pulses on the next cycle.
- **`in_stop`:** in PLAY or DRAIN, go to IDLE at the next edge.
  - `out_valid` is 0 from that edge on.
  - No `out_done`.
- **Ignored:**
  - `in_start` when not in IDLE.
  - `in_start` and `in_stop` together in IDLE (stop wins).
- **Table writes:**
  - Allowed in any state.
  - A same-cycle write and read at the same address returns the old data (read-first).
- **Boundaries:**
  - last_addr = 0 plays a single sample per pass.
  - The pass counter wraps at 2^16 when loops = 0 (the count is irrelevant in that case).

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_busy`=0, `out_done`=0, state=IDLE, counters=0. Table contents are not reset.
- **Start latency:** `in_start` sampled at edge k → `out_busy`=1 after edge k. The RAM reads addr 0 at edge k+1, so `out_valid`=1 with `out_data`=mem[0] after edge k+1.
  - The first sample is visible 2 edges after start is sampled.
- **Throughput:** with `in_dac_ready` held high, one sample per cycle with no gaps, including across pass wraps.
- **Done timing:** final transfer at edge n → after edge n, `out_valid`=0 and `out_busy`=0. `out_done`=1 for exactly the cycle after edge n.
- **Reset mid-play:** all outputs return to their reset values at the next edge.

## Configuration
- Macro: `DAC_PLAYER_SAMPLE_CNT_EN`.
- **Defined:**
  - Adds output port `out_sample_cnt` (32 bits).
  - Counts transfers since the last accepted start and clears on start.
  - Saturates at 2^32−1.
  - Reset value 0.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- **Package `dac_player_pkg`** holds:
  - state enum `t_player_state` {IDLE, PLAY, DRAIN};
  - localparam `INT_LOOP_WIDTH` = 16;
  - localparam `INT_SAMPLE_CNT_WIDTH` = 32.
- **Sub-module `dac_player_bram`:**
  - simple dual-port RAM, one write port and one registered read port with read enable;
  - read-first;
  - infers block RAM.
- **Top level** holds the FSM, counters and valid logic.

## Test plan
1. Load mem[i] = i for i = 0..7; last_addr = 7, loops = 1, start, ready held high → 0..7 on eight consecutive cycles, first sample 2 edges after start, then `out_done` pulses once.
2. Same load, loops = 3 → 24 samples with no gaps, sequence 0..7 repeated 3×; wrap 7→0 has no bubble.
3. Toggle ready 1,0,0,1 during play → `out_data` holds through stalls; no sample is skipped or duplicated; order is 0..7.
4. loops = 0 runs for 100 cycles, then `in_stop` → stream keeps wrapping; `out_valid`=0 and `out_busy`=0 one edge after stop; no `out_done`.
5. last_addr = 0, loops = 2, mem[0] = 0x3FF → exactly two transfers of 0x3FF, then done.
6. Assert `in_rst` mid-play; also `in_start` while busy → all outputs are 0 after the reset edge; the start while busy is ignored and the sequence is not restarted.

Source files
------------

// File: rtl/dac_player_pkg.sv
// Shared types and constants for the DAC waveform player.
// Optional transfer counter is enabled with DAC_PLAYER_SAMPLE_CNT_EN.
package dac_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DRAIN = 2'd2
   } t_player_state;

   localparam int INT_LOOP_WIDTH       = 16;
   localparam int INT_SAMPLE_CNT_WIDTH = 32;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [INT_SAMPLE_CNT_WIDTH-1:0] sat_inc(
      input logic [INT_SAMPLE_CNT_WIDTH-1:0] value
   );
      if (value == {INT_SAMPLE_CNT_WIDTH{1'b1}}) begin
         return value;
      end else begin
         return value + {{(INT_SAMPLE_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/dac_player_bram.sv
// Simple dual-port sample table: one write port, one registered read port
// with read enable, read-first on address collision.
module dac_player_bram #(
   parameter int DATA_WIDTH = 10,
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

   // Table write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; the old word is returned on a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end else begin
         rd_data <= rd_data;
      end
   end

endmodule

// File: rtl/dac_waveform_player.sv
// Streams a software-loaded DAC code table to dac_write as valid/ready samples.
// Define DAC_PLAYER_SAMPLE_CNT_EN to add the out_sample_cnt transfer counter.
module dac_waveform_player
   import dac_player_pkg::*;
#(
   parameter int INT_DAC_DATA_WIDTH = 10,
   parameter int INT_MEM_DEPTH      = 1024,
   parameter int INT_ADDR_WIDTH     = $clog2(INT_MEM_DEPTH)
) (
   input  logic                          in_clk,
   input  logic                          in_rst,
   input  logic                          in_wr_en,
   input  logic [INT_ADDR_WIDTH-1:0]     in_wr_addr,
   input  logic [INT_DAC_DATA_WIDTH-1:0] in_wr_data,
   input  logic [INT_ADDR_WIDTH-1:0]     in_last_addr,
   input  logic [INT_LOOP_WIDTH-1:0]     in_loops,
   input  logic                          in_start,
   input  logic                          in_stop,
   input  logic                          in_dac_ready,
   output logic                          out_valid,
   output logic [INT_DAC_DATA_WIDTH-1:0] out_data,
   output logic                          out_busy,
   output logic                          out_done
`ifdef DAC_PLAYER_SAMPLE_CNT_EN
   ,
   output logic [INT_SAMPLE_CNT_WIDTH-1:0] out_sample_cnt
`endif
);

   localparam logic [INT_ADDR_WIDTH-1:0] ADDR_ZERO = {INT_ADDR_WIDTH{1'b0}};
   localparam logic [INT_ADDR_WIDTH-1:0] ADDR_ONE  = {{(INT_ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INT_LOOP_WIDTH-1:0] LOOP_ZERO = {INT_LOOP_WIDTH{1'b0}};
   localparam logic [INT_LOOP_WIDTH-1:0] LOOP_ONE  = {{(INT_LOOP_WIDTH-1){1'b0}}, 1'b1};

   t_player_state             state_r;
   logic [INT_ADDR_WIDTH-1:0] addr_r;
   logic [INT_ADDR_WIDTH-1:0] last_addr_r;
   logic [INT_LOOP_WIDTH-1:0] pass_r;
   logic [INT_LOOP_WIDTH-1:0] loops_r;

   logic start_acc_s;
   logic rd_en_s;
   logic xfer_s;
   logic wrap_s;
   logic final_read_s;

   assign start_acc_s  = (state_r == IDLE) && in_start && !in_stop;
   // The RAM register only advances when the current sample is leaving or absent.
   assign rd_en_s      = (state_r == PLAY) && (!out_valid || in_dac_ready);
   assign xfer_s       = out_valid && in_dac_ready;
   assign wrap_s       = (addr_r == last_addr_r);
   assign final_read_s = wrap_s && (loops_r != LOOP_ZERO) && (pass_r == (loops_r - LOOP_ONE));

   dac_player_bram #(
      .DATA_WIDTH (INT_DAC_DATA_WIDTH),
      .MEM_DEPTH  (INT_MEM_DEPTH),
      .ADDR_WIDTH (INT_ADDR_WIDTH)
   ) u_bram (
      .clk     (in_clk),
      .rst     (in_rst),
      .wr_en   (in_wr_en),
      .wr_addr (in_wr_addr),
      .wr_data (in_wr_data),
      .rd_en   (rd_en_s),
      .rd_addr (addr_r),
      .rd_data (out_data)
   );

   // Player FSM with address/pass counters and registered status outputs.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_r     <= IDLE;
         addr_r      <= ADDR_ZERO;
         last_addr_r <= ADDR_ZERO;
         pass_r      <= LOOP_ZERO;
         loops_r     <= LOOP_ZERO;
         out_valid   <= 1'b0;
         out_busy    <= 1'b0;
         out_done    <= 1'b0;
      end else begin
         out_done <= 1'b0;
         case (state_r)
            IDLE: begin
               out_valid <= 1'b0;
               if (start_acc_s) begin
                  state_r     <= PLAY;
                  out_busy    <= 1'b1;
                  last_addr_r <= in_last_addr;
                  loops_r     <= in_loops;
                  addr_r      <= ADDR_ZERO;
                  pass_r      <= LOOP_ZERO;
               end else begin
                  out_busy <= 1'b0;
               end
            end
            PLAY: begin
               if (in_stop) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  out_busy  <= 1'b0;
               end else if (rd_en_s) begin
                  out_valid <= 1'b1;
                  if (wrap_s) begin
                     addr_r <= ADDR_ZERO;
                     pass_r <= pass_r + LOOP_ONE;
                  end else begin
                     addr_r <= addr_r + ADDR_ONE;
                  end
                  if (final_read_s) begin
                     state_r <= DRAIN;
                  end else begin
                     state_r <= PLAY;
                  end
               end else if (xfer_s) begin
                  out_valid <= 1'b0;
               end else begin
                  out_valid <= out_valid;
               end
            end
            DRAIN: begin
               if (in_stop) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  out_busy  <= 1'b0;
               end else if (xfer_s) begin
                  state_r   <= IDLE;
                  out_valid <= 1'b0;
                  out_busy  <= 1'b0;
                  out_done  <= 1'b1;
               end else begin
                  state_r <= DRAIN;
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
               out_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DAC_PLAYER_SAMPLE_CNT_EN
   logic [INT_SAMPLE_CNT_WIDTH-1:0] sample_cnt_r;

   // Transfers since the last accepted start, saturating.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         sample_cnt_r <= {INT_SAMPLE_CNT_WIDTH{1'b0}};
      end else if (start_acc_s) begin
         sample_cnt_r <= {INT_SAMPLE_CNT_WIDTH{1'b0}};
      end else if (xfer_s) begin
         sample_cnt_r <= sat_inc(sample_cnt_r);
      end else begin
         sample_cnt_r <= sample_cnt_r;
      end
   end

   assign out_sample_cnt = sample_cnt_r;
`endif

endmodule
